// File: rtl/rd_burst_arb_pkg.sv
// rd_burst_arb_pkg: shared types and constants for the burst-read arbiter
package rd_burst_arb_pkg;
  typedef logic [7:0]  u8_t;
  typedef logic [23:0] u24_t;
  typedef logic [31:0] u32_t;
  typedef logic [63:0] u64_t;
  localparam int RD_BURST_BEATS = 128;
  typedef enum logic [1:0] {Idle, Req, Burst} rdarb_state_t;
endpackage

// File: rtl/rd_burst_arb_if.sv
// rd_burst_arb_if: cache-side request/beat bus plus memory-side burst master bus
interface rd_burst_arb_if import rd_burst_arb_pkg::*; #(parameter int Np = 4);
  logic [Np-1:0] rreq;
  u24_t [Np-1:0] radr;
  logic [Np-1:0] rack;
  u64_t [Np-1:0] rdata;
  logic m_req;
  logic m_gnt;
  u32_t m_adr;
  u8_t  m_len;
  logic m_valid;
  u64_t m_data;
  logic m_last;
  modport master (output rreq, radr, m_gnt, m_valid, m_data, m_last,
                  input  rack, rdata, m_req, m_adr, m_len);
  modport slave  (input  rreq, radr, m_gnt, m_valid, m_data, m_last,
                  output rack, rdata, m_req, m_adr, m_len);
endinterface

// File: rtl/rd_burst_arb_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request after ptr, with wrap
module rr_pick #(
  parameter int Np = 4,
  localparam int PW = Np > 1 ? $clog2(Np) : 1
) (
  input  logic [Np-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] c;
  always_comb begin
    any = 1'b0;
    idx = ptr;
    c = '0;
    for (int k = Np; k >= 1; k--) begin
      c = PW'((int'(ptr) + k) % Np);
      if (req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/rd_burst_arb.sv
// rd_burst_arb: round-robin sharing of one burst-read master among Np input caches
module rd_burst_arb import rd_burst_arb_pkg::*; #(
  parameter int Np = 4,
  parameter int BEATS = RD_BURST_BEATS
) (
  input  logic           aclk,
  input  logic           arst_n,
  input  u32_t           rbase,
  output logic           err,
  rd_burst_arb_if.slave  bus
);
  localparam int PW = Np > 1 ? $clog2(Np) : 1;
  rdarb_state_t state, state_nx;
  logic [PW-1:0] gnt, ptr, idx;
  logic any, last_beat, drain;
  u8_t beat;
  rr_pick #(.Np(Np)) u_pick (.req(bus.rreq), .ptr(ptr), .any(any), .idx(idx));
  assign last_beat = beat == u8_t'(BEATS - 1);
  assign bus.m_len = u8_t'(BEATS - 1);
  always_comb
    state_nx = state == Idle ? (any ? Req : Idle) :
               state == Req  ? (bus.m_gnt ? Burst : Req) :
               (bus.m_valid && last_beat ? Idle : Burst);
  always_ff @(posedge aclk)
    state <= !arst_n ? Idle : state_nx;
  // drain swallows the tail of a burst cut short by reset so it is not flagged as stray
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      gnt <= '0;
      ptr <= PW'(Np - 1);
      beat <= '0;
      drain <= 1'b1;
      err <= 1'b0;
      bus.m_req <= 1'b0;
      bus.m_adr <= '0;
      bus.rack <= '0;
      bus.rdata <= '0;
    end else begin
      bus.rack <= '0;
      if (state == Idle && any) begin
        gnt <= idx;
        bus.m_adr <= rbase + {8'h0, bus.radr[idx]};
        bus.m_req <= 1'b1;
        drain <= 1'b0;
      end
      if (state == Req && bus.m_gnt) begin
        bus.m_req <= 1'b0;
        beat <= '0;
      end
      if (state == Burst && bus.m_valid) begin
        beat <= beat + 8'd1;
        bus.rack[gnt] <= 1'b1;
        bus.rdata[gnt] <= bus.m_data;
        if (last_beat) ptr <= gnt;
        if (bus.m_last != last_beat) err <= 1'b1;
      end
      if (state != Burst && bus.m_valid && !drain) err <= 1'b1;
      if (state != Burst && bus.m_valid && bus.m_last) drain <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rd_burst_arb.sv
// tb_rd_burst_arb: self-checking bench acting as caches and burst master
module tb_rd_burst_arb;
  import rd_burst_arb_pkg::*;
  localparam int NP = 4;
  localparam int NB = 128;
  typedef struct {int ch; u32_t base; u24_t adr; u32_t exp_adr;} vec_t;
  logic aclk = 1'b0;
  logic arst_n = 1'b0;
  u32_t rbase = '0;
  logic err;
  int tests = 0;
  int fails = 0;
  int last_g = NP - 1;
  logic err_m = 1'b0;
  u64_t rd_m [NP];
  vec_t vt [4];
  int order [5];
  rd_burst_arb_if #(.Np(NP)) bif ();
  rd_burst_arb #(.Np(NP), .BEATS(NB)) dut (.aclk(aclk), .arst_n(arst_n), .rbase(rbase), .err(err), .bus(bif.slave));
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rd_vec();
    logic [255:0] r;
    for (int i = 0; i < NP; i++) r[i*64 +: 64] = rd_m[i];
    return r;
  endfunction

  // winner = pending channel with the smallest circular distance past the last served one
  function automatic int rr_model(input logic [NP-1:0] pend, input int last);
    int best = -1;
    int bd = NP;
    for (int i = 0; i < NP; i++)
      if (pend[i] && (i - last - 1 + NP) % NP < bd) begin
        bd = (i - last - 1 + NP) % NP;
        best = i;
      end
    return best;
  endfunction

  task automatic apply_reset();
    arst_n = 1'b0;
    bif.rreq = '0;
    bif.m_valid = 1'b0;
    bif.m_gnt = 1'b0;
    bif.m_last = 1'b0;
    step();
    step();
    arst_n = 1'b1;
    err_m = 1'b0;
    last_g = NP - 1;
    rd_m = '{default: '0};
  endtask

  task automatic serve(input int g, input u32_t adr, input int last_at, input int rst_at, input bit drop_in_req);
    int w = 0;
    u32_t ob;
    u64_t d;
    bit drained;
    while (!bif.m_req && w < 8) begin
      step();
      w++;
    end
    chk("m_req_seen", bif.m_req, 1);
    if (!bif.m_req) return;
    chk("m_adr", bif.m_adr, adr);
    chk("m_len", bif.m_len, NB - 1);
    if (drop_in_req) bif.rreq[g] = 1'b0;
    ob = rbase;
    rbase = $urandom;
    repeat ($urandom_range(0, 2)) begin
      step();
      chk("m_req_hold", bif.m_req, 1);
      chk("m_adr_hold", bif.m_adr, adr);
    end
    rbase = ob;
    bif.m_gnt = 1'b1;
    step();
    bif.m_gnt = 1'b0;
    chk("m_req_drop", bif.m_req, 0);
    for (int i = 0; i < NB; i++) begin
      drained = rst_at >= 0 && i >= rst_at;
      if (i == rst_at) begin
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        err_m = 1'b0;
        last_g = NP - 1;
        rd_m = '{default: '0};
      end
      d = {$urandom, $urandom};
      bif.m_valid = 1'b1;
      bif.m_data = d;
      bif.m_last = drained ? (i == NB - 1) : (i == last_at);
      step();
      bif.m_valid = 1'b0;
      bif.m_last = 1'b0;
      if (drained) begin
        chk("drain_rack", bif.rack, 0);
        chk("drain_m_req", bif.m_req, 0);
        chk("drain_err", err, 0);
        chk("drain_rdata", bif.rdata, rd_vec());
      end else begin
        err_m |= (i == last_at) != (i == NB - 1);
        rd_m[g] = d;
        chk("rack", bif.rack, 1 << g);
        chk("rdata", bif.rdata, rd_vec());
        chk("err", err, err_m);
        if (i == 0) bif.rreq[g] = 1'b0;
        if (i < NB - 1 && $urandom_range(0, 7) == 0) begin
          step();
          chk("gap_rack", bif.rack, 0);
        end
      end
    end
    if (rst_at < 0) begin
      last_g = g;
      chk("bubble_m_req", bif.m_req, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int c;
    vt[0] = '{0, 32'h1000_0000, 24'h000400, 32'h1000_0400};
    vt[1] = '{2, 32'hFFFF_FF00, 24'h000200, 32'h0000_0100};
    vt[2] = '{3, 32'h0000_0010, 24'hFFFFFF, 32'h0100_000F};
    vt[3] = '{1, 32'h8000_0000, 24'h123456, 32'h8012_3456};
    order = '{0, 1, 2, 3, 0};
    bif.radr = '0;
    bif.m_data = '0;
    apply_reset();
    chk("rst_m_req", bif.m_req, 0);
    chk("rst_m_adr", bif.m_adr, 0);
    chk("rst_err", err, 0);
    chk("rst_rack", bif.rack, 0);
    chk("rst_rdata", bif.rdata, 0);
    chk("rst_m_len", bif.m_len, NB - 1);
    for (int k = 0; k < 4; k++) begin
      rbase = vt[k].base;
      bif.radr[vt[k].ch] = vt[k].adr;
      bif.rreq[vt[k].ch] = 1'b1;
      step();
      chk("req_latency", bif.m_req, 1);
      serve(vt[k].ch, vt[k].exp_adr, NB - 1, -1, 1'b0);
    end
    rbase = 32'h0004_0000;
    bif.radr[1] = 24'h00_8000;
    bif.rreq[1] = 1'b1;
    step();
    serve(1, 32'h0004_8000, NB - 1, -1, 1'b1);
    bif.radr[2] = 24'h00_0040;
    bif.rreq[2] = 1'b1;
    step();
    serve(2, 32'h0004_0040, 63, -1, 1'b0);
    repeat (3) step();
    chk("err_sticky", err, 1);
    apply_reset();
    rbase = 32'h2000_0000;
    for (int i = 0; i < NP; i++) bif.radr[i] = 24'(24'h010000 * (i + 1));
    bif.rreq = '1;
    for (int k = 0; k < 5; k++) begin
      serve(order[k], 32'h2000_0000 + 32'(32'h0001_0000 * (order[k] + 1)), NB - 1, -1, 1'b0);
      if (k == 0) bif.rreq[0] = 1'b1;
    end
    chk("rr_no_err", err, 0);
    bif.m_valid = 1'b1;
    step();
    bif.m_valid = 1'b0;
    chk("stray_rack", bif.rack, 0);
    chk("stray_err", err, 1);
    apply_reset();
    rbase = 32'h3000_0000;
    bif.radr[1] = 24'h00_1000;
    bif.rreq[1] = 1'b1;
    step();
    serve(1, 32'h3000_1000, NB - 1, 40, 1'b0);
    bif.radr[2] = 24'h00_2000;
    bif.rreq[2] = 1'b1;
    step();
    chk("post_rst_req", bif.m_req, 1);
    serve(2, 32'h3000_2000, NB - 1, -1, 1'b0);
    chk("post_rst_err", err, 0);
    apply_reset();
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NP; i++)
        if (!bif.rreq[i] && $urandom_range(0, 1) == 1) begin
          bif.rreq[i] = 1'b1;
          bif.radr[i] = 24'($urandom);
        end
      if (bif.rreq == '0) begin
        c = $urandom_range(0, NP - 1);
        bif.rreq[c] = 1'b1;
        bif.radr[c] = 24'($urandom);
      end
      rbase = $urandom;
      g = rr_model(bif.rreq, last_g);
      serve(g, rbase + {8'h0, bif.radr[g]}, ($urandom_range(0, 7) == 0) ? $urandom_range(0, NB - 1) : NB - 1, -1, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
